// File: rtl/led_frame_scheduler.sv
// Round-robin frame loader and MSB-first serializer for an off-chip LED shift driver.
// Build option: define LED_FRAME_PARITY_EN to append an odd-parity bit after frame_q[0].
module led_frame_scheduler #(
    parameter int WIDTH      = 30,
    parameter int NREQ       = 2,
    parameter int BIT_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   frame,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [WIDTH-1:0]        frame_q,
    output logic                    sdo,
    output logic                    sclk,
    output logic                    latch
);
    // state | meaning
    // IDLE  | waiting for a request; all serial outputs low
    // SHIFT | one bit period per transmitted bit, MSB first
    // LATCH | single-cycle latch strobe to the driver
`ifdef LED_FRAME_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BW = $clog2(NBITS);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [WIDTH-1:0]  frame_d;
    logic [BW-1:0]     bit_q, bit_d, bit_nxt;
    logic [CW-1:0]     cyc_q, cyc_d, cyc_nxt;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d, sdo_q, sdo_d, sclk_q, sclk_d, latch_q, latch_d;
    logic [NBITS-1:0]  tx_vec;
    logic              found;
    int                win, idx;

`ifdef LED_FRAME_PARITY_EN
    assign tx_vec = {frame_q, ~^frame_q};
`else
    assign tx_vec = frame_q;
`endif

    assign bit_nxt = bit_q - 1'b1;
    assign cyc_nxt = cyc_q - 1'b1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        gnt_d   = '0;
        busy_d  = busy_q;
        sdo_d   = sdo_q;
        sclk_d  = sclk_q;
        latch_d = 1'b0;
        found   = 1'b0;
        win     = 0;
        idx     = 0;
        // First pending request at or after the pointer, wrapping.
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                sdo_d  = 1'b0;
                sclk_d = 1'b0;
                if (found) begin
                    state_d    = SHIFT;
                    frame_d    = frame[win*WIDTH +: WIDTH];
                    gnt_d[win] = 1'b1;
                    rr_d       = (win == NREQ - 1) ? '0 : PW'(win + 1);
                    busy_d     = 1'b1;
                    bit_d      = BW'(NBITS - 1);
                    cyc_d      = CW'(BIT_CYCLES - 1);
                    sdo_d      = frame[win*WIDTH + WIDTH - 1];
                end
            end
            SHIFT: begin
                if (cyc_q == '0) begin
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = LATCH;
                        latch_d = 1'b1;
                        sdo_d   = 1'b0;
                    end else begin
                        bit_d = bit_nxt;
                        cyc_d = CW'(BIT_CYCLES - 1);
                        sdo_d = tx_vec[bit_nxt];
                    end
                end else begin
                    cyc_d  = cyc_nxt;
                    sclk_d = (int'(cyc_nxt) < BIT_CYCLES / 2);
                end
            end
            LATCH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sdo_d   = 1'b0;
                sclk_d  = 1'b0;
                bit_d   = '0;
                cyc_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            frame_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign sdo   = sdo_q;
    assign sclk  = sclk_q;
    assign latch = latch_q;
endmodule
